// File: rtl/pq_pkg.sv
`default_nettype none
// pq_pkg: shared constants, state encoding and data-word field helpers for pq and pq_timer_sched.
// Rev 1.0
package pq_pkg;

  localparam int QUEUE_DEPTH = 8;
  localparam int TIME_WIDTH  = 16;
  localparam int DATA_WIDTH  = 32;
  localparam int SCHED_NREQ  = 4;
  localparam int LATE_CNT_W  = 16;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } sched_state_e;

  // A pq data word is {deadline, tag}; the deadline sits in the top bits.
  function automatic logic [TIME_WIDTH-1:0] get_deadline(input logic [DATA_WIDTH-1:0] w);
    return w[DATA_WIDTH-1 -: TIME_WIDTH];
  endfunction

  function automatic logic [DATA_WIDTH-TIME_WIDTH-1:0] get_tag(input logic [DATA_WIDTH-1:0] w);
    return w[DATA_WIDTH-TIME_WIDTH-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pq_rr_arb.sv
`default_nettype none
// pq_rr_arb: round-robin arbiter; search starts at rr, rr moves past the winner when en is high.
// Rev 1.0
module pq_rr_arb #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] rr_q, rr_d;
  logic          found;
  int            j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(rr_q) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
    rr_d = rr_q;
    if (en) rr_d = (idx == IW'(N-1)) ? '0 : idx + IW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= '0;
    else         rr_q <= rr_d;
  end

endmodule
`default_nettype wire

// File: rtl/pq_timer_sched.sv
`default_nettype none
// pq_timer_sched: shares one pq among NREQ requesters as a deadline-ordered timer queue.
// Rev 1.0
module pq_timer_sched
  import pq_pkg::*;
#(
  parameter  int NREQ     = SCHED_NREQ,
  parameter  int DEPTH    = QUEUE_DEPTH,
  parameter  int TW       = TIME_WIDTH,
  parameter  int DW       = DATA_WIDTH,
  parameter  int SETTLE   = 1,
  localparam int ID_WIDTH = $clog2(DEPTH) + 1,
  localparam int PW       = DW - TW,
  localparam int IW       = $clog2(NREQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  tick_i,
  output logic [TW-1:0]         now_o,
  input  logic [NREQ-1:0]       req_vld_i,
  input  logic [NREQ*TW-1:0]    req_delay_i,
  input  logic [NREQ*PW-1:0]    req_tag_i,
  output logic [NREQ-1:0]       req_rdy_o,
  output logic                  acc_vld_o,
  output logic [IW-1:0]         acc_idx_o,
  output logic [ID_WIDTH-1:0]   acc_id_o,
  input  logic                  cancel_vld_i,
  input  logic [ID_WIDTH-1:0]   cancel_id_i,
  output logic                  cancel_rdy_o,
  output logic                  exp_vld_o,
  input  logic                  exp_rdy_i,
  output logic [DW-1:0]         exp_data_o,
  output logic                  exp_late_o,
  output logic [LATE_CNT_W-1:0] late_cnt_o,
  output logic                  pq_push_o,
  output logic                  pq_pop_o,
  output logic                  pq_drop_o,
  output logic [ID_WIDTH-1:0]   pq_drop_id_o,
  output logic [DW-1:0]         pq_data_o,
  input  logic [ID_WIDTH-1:0]   pq_push_id_i,
  input  logic                  pq_push_rdy_i,
  input  logic                  pq_pop_rdy_i,
  input  logic                  pq_drop_rdy_i,
  input  logic                  pq_full_i,
  input  logic                  pq_peek_vld_i,
  input  logic [DW-1:0]         pq_peek_data_i
);

  localparam int            CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [TW-1:0] TMAX = '1;

  sched_state_e          state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         now_q, now_d;
  logic                  exp_vld_q, exp_vld_d;
  logic [DW-1:0]         exp_data_q, exp_data_d;
  logic                  exp_late_q, exp_late_d;
  logic [LATE_CNT_W-1:0] late_cnt_q, late_cnt_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic [TW-1:0]   peek_dl, sel_delay, deadline;
  logic [PW-1:0]   sel_tag;
  logic [TW:0]     dl_sum;
  logic            is_idle, exp_cond, is_late, do_pop, do_drop, do_push;

  pq_rr_arb #(.N(NREQ)) u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req    (req_vld_i),
    .en     (do_push),
    .gnt    (arb_gnt),
    .idx    (arb_idx)
  );

  assign peek_dl   = pq_peek_data_i[DW-1 -: TW];
  assign sel_delay = req_delay_i[arb_idx*TW +: TW];
  assign sel_tag   = req_tag_i[arb_idx*PW +: PW];
  assign dl_sum    = {1'b0, now_q} + {1'b0, sel_delay};
  assign deadline  = dl_sum[TW] ? TMAX : dl_sum[TW-1:0];

  assign is_idle  = (state_q == ST_IDLE);
  assign exp_cond = pq_peek_vld_i && (peek_dl <= now_q);
  assign is_late  = (now_q > peek_dl);
  // Fixed priority pop > drop > push keeps at most one pq strobe per cycle.
  assign do_pop   = is_idle && exp_cond && (!exp_vld_q || exp_rdy_i) && pq_pop_rdy_i;
  assign do_drop  = is_idle && !do_pop && cancel_vld_i && pq_drop_rdy_i;
  assign do_push  = is_idle && !do_pop && !do_drop && (|req_vld_i) && pq_push_rdy_i && !pq_full_i;

  always_comb begin
    now_d      = now_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    exp_vld_d  = exp_vld_q;
    exp_data_d = exp_data_q;
    exp_late_d = exp_late_q;
    late_cnt_d = late_cnt_q;

    if (tick_i && (now_q != TMAX)) now_d = now_q + TW'(1);

    case (state_q)
      ST_IDLE: begin
        if (do_pop || do_drop || do_push) begin
          state_d = ST_SETTLE;
          cnt_d   = CW'(SETTLE - 1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    // A pop in the handshake cycle reloads the buffer without a bubble.
    if (do_pop) begin
      exp_vld_d  = 1'b1;
      exp_data_d = pq_peek_data_i;
      exp_late_d = is_late;
      if (is_late && (late_cnt_q != '1)) late_cnt_d = late_cnt_q + LATE_CNT_W'(1);
    end else if (exp_vld_q && exp_rdy_i) begin
      exp_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      now_q      <= '0;
      exp_vld_q  <= 1'b0;
      exp_data_q <= '0;
      exp_late_q <= 1'b0;
      late_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      now_q      <= now_d;
      exp_vld_q  <= exp_vld_d;
      exp_data_q <= exp_data_d;
      exp_late_q <= exp_late_d;
      late_cnt_q <= late_cnt_d;
    end
  end

  assign now_o        = now_q;
  assign exp_vld_o    = exp_vld_q;
  assign exp_data_o   = exp_data_q;
  assign exp_late_o   = exp_late_q;
  assign late_cnt_o   = late_cnt_q;

  assign pq_push_o    = do_push;
  assign pq_pop_o     = do_pop;
  assign pq_drop_o    = do_drop;
  assign pq_drop_id_o = cancel_id_i;
  assign pq_data_o    = {deadline, sel_tag};

  assign req_rdy_o    = do_push ? arb_gnt : '0;
  assign acc_vld_o    = do_push;
  assign acc_idx_o    = do_push ? arb_idx : '0;
  assign acc_id_o     = do_push ? pq_push_id_i : '0;
  assign cancel_rdy_o = do_drop;

endmodule
`default_nettype wire

// File: tb/tb_pq_timer_sched.sv
`default_nettype none
// tb_pq_timer_sched: directed scoreboard bench with a behavioural pq model behind the scheduler.
// Rev 1.0
module tb_pq_timer_sched;
  import pq_pkg::*;

  localparam int NREQ = 4, DEPTH = 8, TW = 16, DW = 32, PW = 16, IDW = 4, IW = 2, SETTLE = 1;

  logic clk, rst_n, tick;
  logic [TW-1:0]      now_o;
  logic [NREQ-1:0]    req_vld, req_rdy;
  logic [NREQ*TW-1:0] req_delay;
  logic [NREQ*PW-1:0] req_tag;
  logic               acc_vld;
  logic [IW-1:0]      acc_idx;
  logic [IDW-1:0]     acc_id, cancel_id, pq_drop_id, pq_push_id;
  logic               cancel_vld, cancel_rdy, exp_vld, exp_rdy, exp_late;
  logic [DW-1:0]      exp_data, pq_data, peek_data;
  logic [15:0]        late_cnt;
  logic               pq_push, pq_pop, pq_drop, pq_full, peek_vld, force_full;

  pq_timer_sched #(.NREQ(NREQ), .DEPTH(DEPTH), .TW(TW), .DW(DW), .SETTLE(SETTLE)) dut (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .now_o(now_o),
    .req_vld_i(req_vld), .req_delay_i(req_delay), .req_tag_i(req_tag), .req_rdy_o(req_rdy),
    .acc_vld_o(acc_vld), .acc_idx_o(acc_idx), .acc_id_o(acc_id),
    .cancel_vld_i(cancel_vld), .cancel_id_i(cancel_id), .cancel_rdy_o(cancel_rdy),
    .exp_vld_o(exp_vld), .exp_rdy_i(exp_rdy), .exp_data_o(exp_data), .exp_late_o(exp_late),
    .late_cnt_o(late_cnt),
    .pq_push_o(pq_push), .pq_pop_o(pq_pop), .pq_drop_o(pq_drop), .pq_drop_id_o(pq_drop_id),
    .pq_data_o(pq_data), .pq_push_id_i(pq_push_id), .pq_push_rdy_i(1'b1), .pq_pop_rdy_i(1'b1),
    .pq_drop_rdy_i(1'b1), .pq_full_i(pq_full), .pq_peek_vld_i(peek_vld), .pq_peek_data_i(peek_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pq model: 16 id slots, smallest deadline first, ties to the lowest id.
  logic [15:0]   m_vld;
  logic [DW-1:0] m_data [16];
  logic [IDW-1:0] peek_id;
  int            m_cnt;
  logic          free_found;

  always_comb begin
    peek_vld = 1'b0; peek_id = '0; peek_data = '0; pq_push_id = '0; free_found = 1'b0; m_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (m_vld[i]) begin
        m_cnt = m_cnt + 1;
        if (!peek_vld || (get_deadline(m_data[i]) < get_deadline(peek_data))) begin
          peek_vld = 1'b1; peek_id = IDW'(i); peek_data = m_data[i];
        end
      end else if (!free_found) begin
        free_found = 1'b1; pq_push_id = IDW'(i);
      end
    end
    pq_full = (m_cnt >= DEPTH) || force_full;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_vld <= '0;
    else begin
      if (pq_push) begin m_vld[pq_push_id] <= 1'b1; m_data[pq_push_id] <= pq_data; end
      if (pq_pop)  m_vld[peek_id] <= 1'b0;
      if (pq_drop) m_vld[pq_drop_id] <= 1'b0;
    end
  end

  typedef struct { logic [DW-1:0] data; logic late; int now_at; } exp_t;
  typedef struct { int idx; int id; } acc_t;
  exp_t exp_q [$];
  acc_t acc_q [$];

  int n_vec = 0, n_err = 0;
  int cyc = 0, last_acc = -1, n_pops = 0;
  logic spacing_on = 1'b0;
  exp_t mon_e;
  acc_t mon_a;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops expected responses whenever the DUT presents an expiry or a grant.
  always @(negedge clk) begin
    cyc++;
    if (!spacing_on) last_acc = -1;
    if (rst_n) begin
      if (pq_pop) n_pops++;
      if (pq_push || pq_pop || pq_drop)
        chk("one_strobe", 64'(int'(pq_push) + int'(pq_pop) + int'(pq_drop)), 64'd1);
      if (pq_full) chk("push_while_full", {63'd0, pq_push}, 64'd0);
      if (exp_vld && exp_rdy) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_expiry: got 0x%0h expected none", exp_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("exp_data", 64'(exp_data), 64'(mon_e.data));
          chk("exp_late", {63'd0, exp_late}, {63'd0, mon_e.late});
          if (mon_e.now_at >= 0) chk("exp_now", 64'(now_o), 64'(mon_e.now_at));
        end
      end
      if (acc_vld) begin
        if (acc_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_grant: got idx %0d expected none", acc_idx);
        end else begin
          mon_a = acc_q.pop_front();
          chk("acc_idx", 64'(acc_idx), 64'(mon_a.idx));
          chk("acc_id", 64'(acc_id), 64'(mon_a.id));
          chk("req_rdy", 64'(req_rdy), 64'(4'b0001 << mon_a.idx));
        end
        if (spacing_on && last_acc >= 0) chk("acc_spacing", 64'(cyc - last_acc), 64'(1 + SETTLE));
        last_acc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    chk("sb_drained", 64'(exp_q.size() + acc_q.size()), 64'd0);
    rst_n = 1'b0; req_vld = '0; cancel_vld = 1'b0; force_full = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic push_req(input int r, input int dly, input int tag, input int exp_id);
    logic got;
    acc_q.push_back('{r, exp_id});
    req_vld[r] = 1'b1; req_delay[r*TW +: TW] = TW'(dly); req_tag[r*PW +: PW] = PW'(tag);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1; if (req_rdy[r]) got = 1'b1;
      @(posedge clk); #2;
    end
    req_vld[r] = 1'b0;
    chk("push_grant", {63'd0, got}, 64'd1);
  endtask

  task automatic wait_drain(input int maxc);
    for (int i = 0; i < maxc && exp_q.size() > 0; i++) step();
    chk("exp_drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants, pops_base, pop_k, drop_k, push_k;
    logic got;
    rst_n = 1'b0; tick = 1'b1; req_vld = '0; req_delay = '0; req_tag = '0;
    cancel_vld = 1'b0; cancel_id = '0; exp_rdy = 1'b1; force_full = 1'b0;
    step(); step(); step();
    chk("rst_now", 64'(now_o), 64'd0);
    chk("rst_exp", {29'd0, exp_vld, exp_late, late_cnt, exp_data}, 64'd0);
    chk("rst_ctl", {50'd0, pq_push, pq_pop, pq_drop, req_rdy, acc_vld, acc_idx, acc_id, cancel_rdy}, 64'd0);

    // Time base counts from reset and clears asynchronously.
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin step(); chk("now_count", 64'(now_o), 64'(k)); end
    rst_n = 1'b0; #1;
    chk("now_async_clear", 64'(now_o), 64'd0);
    step(); rst_n = 1'b1;

    // Two pushes at now=10, expiring in deadline order.
    for (int k = 0; k < 10; k++) step();
    tick = 1'b0;
    chk("now_at_10", 64'(now_o), 64'd10);
    exp_q.push_back('{{16'd12, 16'h000B}, 1'b0, 13});
    exp_q.push_back('{{16'd15, 16'h000A}, 1'b0, 16});
    push_req(0, 5, 'hA, 0);
    push_req(1, 2, 'hB, 1);
    tick = 1'b1;
    wait_drain(40);

    // Round-robin with all requesters valid, then a full-queue stall.
    tick = 1'b0; do_reset();
    for (int r = 0; r < 4; r++) acc_q.push_back('{r, r});
    acc_q.push_back('{0, 4});
    for (int r = 0; r < 4; r++) begin req_delay[r*TW +: TW] = 16'd1000; req_tag[r*PW +: PW] = PW'(r); end
    spacing_on = 1'b1; req_vld = 4'hF; grants = 0;
    for (int i = 0; i < 30 && grants < 5; i++) begin
      #1; if (acc_vld) grants++;
      step();
    end
    req_vld = '0; spacing_on = 1'b0;
    chk("rr_grants", 64'(grants), 64'd5);
    force_full = 1'b1; req_vld[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin #1; chk("stall_full", {63'd0, acc_vld}, 64'd0); step(); end
    force_full = 1'b0;
    push_req(1, 1000, 'h55, 5);

    // Cancel of id 3 suppresses its expiry.
    do_reset();
    push_req(0, 500, 1, 0); push_req(1, 500, 2, 1); push_req(2, 500, 3, 2); push_req(3, 20, 'hC, 3);
    pops_base = n_pops; tick = 1'b1;
    for (int i = 0; i < 5; i++) step();
    cancel_vld = 1'b1; cancel_id = 4'd3; got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      if (cancel_rdy) begin
        got = 1'b1;
        chk("drop_id", 64'(pq_drop_id), 64'd3);
        chk("drop_strobe", {63'd0, pq_drop}, 64'd1);
      end
      step();
    end
    cancel_vld = 1'b0;
    chk("cancel_pulse", {63'd0, got}, 64'd1);
    for (int i = 0; i < 30; i++) step();
    chk("no_pop_after_cancel", 64'(n_pops - pops_base), 64'd0);
    chk("peek_after_cancel", 64'(get_deadline(peek_data)), 64'd500);

    // Held expiry buffer, then back-to-back reload of a late entry.
    tick = 1'b0; do_reset(); exp_rdy = 1'b0;
    push_req(0, 3, 1, 0); push_req(1, 4, 2, 1);
    exp_q.push_back('{{16'd3, 16'd1}, 1'b0, -1});
    exp_q.push_back('{{16'd4, 16'd2}, 1'b1, -1});
    pops_base = n_pops; tick = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (exp_vld) chk("held_stable", 64'(exp_data), 64'({16'd3, 16'd1}));
    end
    chk("held_vld", {63'd0, exp_vld}, 64'd1);
    chk("single_pop", 64'(n_pops - pops_base), 64'd1);
    exp_rdy = 1'b1; #1;
    chk("b2b_pop", {63'd0, pq_pop}, 64'd1);
    step(); exp_rdy = 1'b0;
    chk("b2b_vld", {63'd0, exp_vld}, 64'd1);
    chk("b2b_data", 64'(exp_data), 64'({16'd4, 16'd2}));
    chk("b2b_late", {63'd0, exp_late}, 64'd1);
    chk("late_cnt", 64'(late_cnt), 64'd1);
    exp_rdy = 1'b1; step();
    chk("held_drained", 64'(exp_q.size()), 64'd0);

    // Expiry, cancel and push requested in the same cycle.
    tick = 1'b0; do_reset(); exp_rdy = 1'b0;
    exp_q.push_back('{{16'd0, 16'h0011}, 1'b0, -1});
    exp_q.push_back('{{16'd0, 16'h0022}, 1'b0, -1});
    push_req(0, 0, 'h11, 0); push_req(1, 0, 'h22, 0); push_req(2, 50, 'h33, 1);
    step(); step(); step();
    acc_q.push_back('{3, 0});
    exp_rdy = 1'b1; cancel_vld = 1'b1; cancel_id = 4'd1;
    req_vld[3] = 1'b1; req_delay[3*TW +: TW] = 16'd7; req_tag[3*PW +: PW] = 16'h0044;
    pop_k = -1; drop_k = -1; push_k = -1;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (pq_pop)  pop_k = k;
      if (pq_drop) drop_k = k;
      if (pq_push) push_k = k;
      step();
      if (drop_k >= 0) cancel_vld = 1'b0;
      if (push_k >= 0) req_vld[3] = 1'b0;
    end
    chk("order_pop", 64'(pop_k), 64'd0);
    chk("order_drop", 64'(drop_k), 64'd2);
    chk("order_push", 64'(push_k), 64'd4);
    chk("final_drain", 64'(exp_q.size() + acc_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pq_timer_sched.md
# pq_timer_sched

Timer scheduler that owns one `pq` instance and shares it between `NREQ` requesters. It keeps a free-running time base and turns relative-delay requests into absolute-deadline entries. Cancel requests become `drop` operations. When the head entry's deadline has arrived, the block pops it and presents it on a one-entry expiry output buffer. It sits directly in front of `pq`, and every `pq` control input is driven only by this block.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (≥2)
- `DEPTH`, `QUEUE_DEPTH`, depth of the attached `pq`
- `TW`, `TIME_WIDTH`, time field width
- `SETTLE`, 1, idle cycles after any accepted `pq` operation before re-evaluating peek (≥1)
- derived: `ID_WIDTH = $clog2(DEPTH)+1`, `PW = DW-TW`

Ports:
- `clk_i` in 1: clock
- `rst_ni` in 1: reset. One clock; reset is asynchronous and active-low.
- `tick_i` in 1: advance time base by one when high
- `now_o` out TW: current time
- `req_vld_i` in NREQ: per-requester request valid
- `req_delay_i` in NREQ×TW: relative delay
- `req_tag_i` in NREQ×PW: payload
- `req_rdy_o` out NREQ: one-hot grant, asserted in the push cycle
- `acc_vld_o` out 1: push accepted this cycle
- `acc_idx_o` out $clog2(NREQ): granted requester
- `acc_id_o` out ID_WIDTH: `pq` entry id
- `cancel_vld_i` in 1: cancel request
- `cancel_id_i` in ID_WIDTH: id to drop
- `cancel_rdy_o` out 1: drop issued this cycle
- `exp_vld_o` out 1: expiry output valid
- `exp_rdy_i` in 1: expiry output ready
- `exp_data_o` out DW: expired word {deadline, tag}
- `exp_late_o` out 1: `now` > deadline at pop
- `late_cnt_o` out 16: saturating count of late expiries
- `pq_push_o`, `pq_pop_o`, `pq_drop_o` out 1 each; `pq_drop_id_o` out ID_WIDTH; `pq_data_o` out DW: to `pq`
- `pq_push_id_i` in ID_WIDTH; `pq_push_rdy_i`, `pq_pop_rdy_i`, `pq_drop_rdy_i`, `pq_full_i`, `pq_peek_vld_i` in 1 each; `pq_peek_data_i` in DW: from `pq`

## Operation
- `pq` data word is {deadline[TW-1:0], tag[PW-1:0]}. `pq` orders entries by the deadline field, smallest first.
- Time base: `now` increments when `tick_i` is high and saturates at 2^TW−1.
- Deadline computation: deadline = `now` + delay, as a saturating add at 2^TW−1.
- Expiry condition: `pq_peek_vld_i` high and peek deadline ≤ `now`, using an unsigned compare.
- FSM has two states, IDLE and SETTLE. At most one `pq` operation is issued per cycle, and only in IDLE.
- Priority in IDLE:
  1. POP, when the expiry condition holds, `exp_vld_o` is low (or `exp_rdy_i` is high this cycle), and `pq_pop_rdy_i` is high.
  2. DROP, when `cancel_vld_i` and `pq_drop_rdy_i` are high.
  3. PUSH, when some `req_vld_i` is high, `pq_push_rdy_i` is high, and `pq_full_i` is low.
- Accepted operation:
  - The selected strobe is high for exactly one cycle.
  - The FSM enters SETTLE for `SETTLE` cycles, counted by a down-counter, then returns to IDLE.
  - No strobes are issued in SETTLE.
- POP:
  - `pq_peek_data_i` is captured into the expiry buffer; `exp_vld_o` rises the next cycle.
  - `exp_late_o` is set to (`now` > deadline) at capture.
  - `late_cnt_o` increments at capture when late, saturating at 0xFFFF.
- Expiry buffer: holds until `exp_vld_o && exp_rdy_i`. A pop in the same cycle as that handshake reloads the buffer back-to-back.
- PUSH arbitration:
  - Round-robin, searching from pointer `rr`.
  - After a grant to requester g, `rr` becomes (g+1) mod NREQ.
  - `req_rdy_o[g]`, `acc_vld_o`, `acc_idx_o=g` and `acc_id_o=pq_push_id_i` are driven combinationally in the push cycle.
- DROP: `pq_drop_id_o = cancel_id_i`, and `cancel_rdy_o` is high in the drop cycle. Dropping a stale or unknown id is the requester's responsibility.
- `pq_push_o`, `pq_pop_o` and `pq_drop_o` are never asserted simultaneously. The block never pushes while `pq_full_i` is high, so `pq` overflow is unreachable.

## Timing
- Reset values:
  - `now_o`=0, `rr`=0, FSM=IDLE, settle counter=0.
  - `exp_vld_o`=0, `exp_data_o`=0, `exp_late_o`=0, `late_cnt_o`=0.
  - All `pq` strobes=0, all `req_rdy_o`=0, `acc_*`=0, `cancel_rdy_o`=0.
- Reset mid-operation clears the buffer and FSM. A pending expiry is lost. `pq` shares `rst_ni`.
- Push latency: request to strobe is 0 cycles when IDLE and uncontested.
- Minimum spacing between `pq` operations is 1+`SETTLE` cycles.
- Expiry latency: from deadline ≤ `now` to `exp_vld_o` is 1 cycle when IDLE and the buffer is free.
- Simultaneous events:
  - An expiry blocks cancel and push in that cycle.
  - Cancel blocks push.
  - Requesters must hold `req_vld_i` stable until granted.
- Empty `pq` (`pq_peek_vld_i`=0): no pop is issued.
- Full `pq`: pushes stall, while drops and pops proceed.

## Structure
- `pq_pkg` gains `SCHED_NREQ`, the data-word field helpers (`get_deadline`, `get_tag`), and the late counter width constant.
- The round-robin arbiter is a natural sub-module, `pq_rr_arb`, with ports `req`, `en`, `gnt` (one-hot) and `idx`. The pointer is updated on `en`.
- The FSM, time base and expiry buffer stay in `pq_timer_sched`.

## Test plan
- Reset with `tick_i`=1. Then:
  - `now_o` counts 0,1,2…
  - All outputs hold their reset values while `rst_ni`=0.
  - Asserting `rst_ni` low mid-count clears `now_o` asynchronously.
- Push with `now`=10: req0 delay 5 tag 0xA, then req1 delay 2 tag 0xB.
  - `exp_data_o` deadline 12 tag 0xB appears at `now`=13.
  - Deadline 15 tag 0xA appears at `now`=16.
  - Both have `exp_late_o`=0.
- All 4 requesters valid continuously with `rr`=0:
  - Grants occur in order 0,1,2,3,0.
  - Consecutive grants are 1+`SETTLE` cycles apart.
  - No push is issued while `pq_full_i`=1.
- Push id 3 with delay 20, then cancel id 3 at `now`+5:
  - `cancel_rdy_o` pulses.
  - No expiry occurs through `now`+30.
- Hold `exp_rdy_i`=0 while two deadlines pass:
  - A single `exp_vld_o` is held stable and no second pop is issued.
  - Releasing `exp_rdy_i` for 1 cycle pops the second entry back-to-back.
  - `exp_late_o`=1 and `late_cnt_o`=1 for it.
- Same-cycle expiry, cancel and push:
  - Pop is issued first, then drop, then push, in the successive IDLE windows.
  - Only one strobe is high per cycle.
